// File: rtl/prng_scheduler.sv
// Shares one 128-bit, 5-bit-per-step LFSR among NUM_REQ requesters: seeds it, warms it up,
// then serves round-robin grants, stepping the LFSR STEPS_PER_WORD times per delivered word.
module prng_scheduler #(
  parameter int NUM_REQ        = 4,
  parameter int WARMUP_STEPS   = 8,
  parameter int STEPS_PER_WORD = 26
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               seed_valid,
  input  logic [127:0]       seed,
  output logic               seed_ready,
  output logic               seeded,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic               rnd_valid,
  output logic [127:0]       rnd_data,
  output logic               lfsr_enable,
  output logic               lfsr_load_seed,
  output logic [127:0]       lfsr_seed,
  input  logic [127:0]       lfsr_value
);

  localparam int MAXS = (WARMUP_STEPS > STEPS_PER_WORD) ? WARMUP_STEPS : STEPS_PER_WORD;
  localparam int CW   = $clog2(MAXS + 1);
  localparam int PW   = $clog2(NUM_REQ);

  typedef enum logic [2:0] {UNSEEDED, LOAD, WARMUP, IDLE, STEP, DELIVER} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [PW-1:0] rr_ptr, owner, win_idx, j_idx;
  logic [127:0]  seed_q;
  logic          keep, win_found;
  int            j;

  // First set request at or above rr_ptr, wrapping back to requester 0.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    j         = 0;
    j_idx     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = 32'(rr_ptr) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      j_idx = PW'(j);
      if (!win_found && req[j_idx]) begin
        win_found = 1'b1;
        win_idx   = j_idx;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= UNSEEDED;
      cnt    <= '0;
      rr_ptr <= '0;
      owner  <= '0;
      seed_q <= '0;
      seeded <= 1'b0;
      keep   <= 1'b0;
    end else begin
      case (state)
        UNSEEDED: if (seed_valid) begin
          seed_q <= seed;
          state  <= LOAD;
        end
        LOAD: if (WARMUP_STEPS == 0) begin
          state  <= IDLE;
          seeded <= 1'b1;
        end else begin
          state <= WARMUP;
          cnt   <= CW'(WARMUP_STEPS);
        end
        WARMUP: begin
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            state  <= IDLE;
            seeded <= 1'b1;
          end
        end
        IDLE: if (seed_valid) begin
          seed_q <= seed;
          seeded <= 1'b0;
          state  <= LOAD;
        end else if (win_found) begin
          owner <= win_idx;
          cnt   <= CW'(STEPS_PER_WORD);
          state <= STEP;
        end
        STEP: begin
          cnt <= cnt - 1'b1;
          // Owner's request is sampled on the last step so delivery decodes from registers only.
          keep <= req[owner];
          if (cnt == CW'(1)) state <= DELIVER;
        end
        DELIVER: begin
          rr_ptr <= (owner == PW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
          keep   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= UNSEEDED;
      endcase
    end
  end

  always_comb begin
    seed_ready     = (state == UNSEEDED) || (state == IDLE);
    lfsr_enable    = (state == LOAD) || (state == WARMUP) || (state == STEP);
    lfsr_load_seed = (state == LOAD);
    lfsr_seed      = (state == LOAD) ? seed_q : '0;
    rnd_valid      = (state == DELIVER) && keep;
    grant          = rnd_valid ? (NUM_REQ'(1) << owner) : '0;
    rnd_data       = rnd_valid ? lfsr_value : '0;
  end

endmodule

// File: tb/tb_prng_scheduler.sv
// Directed bench for prng_scheduler with a behavioural 128-bit LFSR attached to the LFSR ports.
module tb_prng_scheduler;

  logic         clock = 1'b0;
  logic         reset, seed_valid, seed_ready, seeded;
  logic [127:0] seed, rnd_data, lfsr_seed, lfsr_value;
  logic [3:0]   req, grant;
  logic         rnd_valid, lfsr_enable, lfsr_load_seed;

  int tests = 0;
  int fails = 0;
  logic [127:0] cur;

  always #5 clock = ~clock;

  prng_scheduler #(.NUM_REQ(4), .WARMUP_STEPS(8), .STEPS_PER_WORD(26)) dut (
    .clock(clock), .reset(reset), .seed_valid(seed_valid), .seed(seed),
    .seed_ready(seed_ready), .seeded(seeded), .req(req), .grant(grant),
    .rnd_valid(rnd_valid), .rnd_data(rnd_data), .lfsr_enable(lfsr_enable),
    .lfsr_load_seed(lfsr_load_seed), .lfsr_seed(lfsr_seed), .lfsr_value(lfsr_value)
  );

  // Taps 128,126,101,99; five shifts per step.
  function automatic logic [127:0] stepn(input logic [127:0] s, input int n);
    logic [127:0] v;
    logic fb;
    v = s;
    for (int k = 0; k < n; k++)
      for (int b = 0; b < 5; b++) begin
        fb = v[127] ^ v[125] ^ v[100] ^ v[98];
        v  = {v[126:0], fb};
      end
    return v;
  endfunction

  logic [127:0] lfsr_q = '0;
  always @(posedge clock)
    if (lfsr_enable) lfsr_q <= lfsr_load_seed ? lfsr_seed : stepn(lfsr_q, 1);
  assign lfsr_value = lfsr_q;

  typedef struct {
    logic [3:0] req_start;
    int         hold;
    logic [3:0] req_rest;
    logic [3:0] exp_grant;
    logic       exp_valid;
  } vec_t;

  vec_t vecs[9];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Call in a cycle where the scheduler accepts a seed; returns in the first IDLE cycle.
  task automatic do_seed(input logic [127:0] s);
    int n;
    logic bad;
    seed = s;
    seed_valid = 1'b1;
    tick();
    seed_valid = 1'b0;
    chk("load_cycle", {124'd0, lfsr_load_seed, lfsr_enable, seeded, seed_ready}, 128'b1100);
    chk("load_seed_val", lfsr_seed, s);
    chk("load_grant", {123'd0, rnd_valid, grant}, 128'd0);
    n = 0;
    bad = 1'b0;
    tick();
    while (lfsr_enable && n < 50) begin
      if (lfsr_load_seed || rnd_valid || seeded) bad = 1'b1;
      n++;
      tick();
    end
    chk("warmup_len", 128'(n), 128'd8);
    chk("warmup_clean", {127'd0, bad}, 128'd0);
    chk("seeded_idle", {126'd0, seeded, seed_ready}, 128'b11);
    cur = stepn(s, 8);
    chk("warm_value", lfsr_value, cur);
  endtask

  // Call in an IDLE cycle; returns in the IDLE cycle following delivery.
  task automatic run_vec(input vec_t e, input int idx);
    int n_en;
    logic early;
    string nm;
    nm = $sformatf("vec%0d", idx);
    req = e.req_start;
    n_en = 0;
    early = 1'b0;
    for (int k = 1; k <= 26; k++) begin
      tick();
      if (k >= e.hold) req = e.req_rest;
      if (lfsr_enable && !seed_ready && !lfsr_load_seed) n_en++;
      if (rnd_valid || grant != 4'd0) early = 1'b1;
    end
    chk({nm, "_steps"}, 128'(n_en), 128'd26);
    chk({nm, "_early"}, {127'd0, early}, 128'd0);
    tick();
    chk({nm, "_grant"}, {123'd0, rnd_valid, grant}, {123'd0, e.exp_valid, e.exp_grant});
    cur = stepn(cur, 26);
    chk({nm, "_data"}, rnd_data, e.exp_valid ? cur : 128'd0);
    chk({nm, "_deliver_en"}, {127'd0, lfsr_enable}, 128'd0);
    tick();
    chk({nm, "_idle_back"}, {126'd0, seed_ready, lfsr_enable}, 128'b10);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int bad_cnt;
    vecs[0] = '{4'b1111, 255, 4'b1111, 4'b0001, 1'b1};
    vecs[1] = '{4'b1111, 255, 4'b1111, 4'b0010, 1'b1};
    vecs[2] = '{4'b1111, 255, 4'b1111, 4'b0100, 1'b1};
    vecs[3] = '{4'b1111, 255, 4'b1111, 4'b1000, 1'b1};
    vecs[4] = '{4'b1111, 255, 4'b1111, 4'b0001, 1'b1};
    vecs[5] = '{4'b0010, 3,   4'b0000, 4'b0000, 1'b0};
    vecs[6] = '{4'b1011, 255, 4'b1011, 4'b1000, 1'b1};
    vecs[7] = '{4'b0011, 255, 4'b0011, 4'b0001, 1'b1};
    vecs[8] = '{4'b0100, 255, 4'b0100, 4'b0100, 1'b1};

    reset = 1'b1;
    req = 4'b1111;
    seed_valid = 1'b0;
    seed = '0;
    cur = '0;

    for (int c = 0; c < 2; c++) begin
      tick();
      chk("rst_ctrl", {120'd0, grant, rnd_valid, lfsr_enable, lfsr_load_seed, seeded}, 128'd0);
      chk("rst_data", rnd_data | lfsr_seed, 128'd0);
      chk("rst_ready", {127'd0, seed_ready}, 128'd1);
    end
    reset = 1'b0;
    tick();
    chk("unseeded_ignores_req", {121'd0, grant, rnd_valid, lfsr_enable, seed_ready}, 128'd1);
    req = 4'b0000;

    do_seed(128'h0123456789ABCDEF0123456789ABCDEF);
    for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

    // Seed and request offered together: seed wins, request served after warm-up.
    req = 4'b0100;
    do_seed(128'hDEADBEEF0BADF00DCAFEBABE12345678);
    run_vec('{4'b0100, 255, 4'b0100, 4'b0100, 1'b1}, 9);

    // Reset during the 10th step of a word.
    req = 4'b1111;
    for (int k = 1; k <= 10; k++) tick();
    chk("mid_step_enable", {127'd0, lfsr_enable}, 128'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_state", {121'd0, grant, rnd_valid, lfsr_enable, seeded}, 128'd0);
    chk("mid_rst_ready", {127'd0, seed_ready}, 128'd1);
    bad_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (lfsr_enable || rnd_valid || grant != 4'd0 || seeded) bad_cnt++;
    end
    chk("post_rst_idle", 128'(bad_cnt), 128'd0);
    do_seed(128'h00000000000000000000000000000001);
    run_vec('{4'b1111, 255, 4'b1111, 4'b0001, 1'b1}, 10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
